systolic_ctrl: RTL

- Sequencer for a ROWS x COLS grid of signed MAC array slices.
- X moves across each row through a one-cycle register per slice; partial sums Y move down each column through a one-cycle register per slice.
- Per job the block:
  - loads weights row by row;
  - accepts input vectors over a valid/ready handshake;
  - generates the per-row skew enables for X;
  - flags exactly when each column's bottom Yout carries a finished result.
- The datapath (skew registers, weight registers) sits outside the block; this block owns timing only.

---
 rtl/systolic_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// Timing sequencer for a ROWS x COLS systolic MAC array: weight load, input
// handshake, skewed X-injection enables and per-column result-valid flags.
module systolic_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      num_vec,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      w_load,
  output logic [$clog2(ROWS)-1:0]   w_row_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ROWS-1:0]           x_feed_en,
  output logic [COLS-1:0]           y_valid,
  output logic [CNT_WIDTH-1:0]      vec_cnt
);

  localparam int RSW = $clog2(ROWS);
  localparam int DL  = ROWS + COLS;
  localparam logic [RSW-1:0] LAST_ROW = RSW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_FEED,
    S_DRAIN
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [RSW-1:0]         r_row;
  logic [CNT_WIDTH-1:0]   r_num_vec;
  logic [CNT_WIDTH-1:0]   r_vec_cnt;
  logic [DL-1:0]          r_dly;

  logic                   w_feed_ok;
  logic                   w_accept;
  logic                   w_start_take;
  logic                   w_drain_empty;
  logic [CNT_WIDTH-1:0]   w_vec_cnt_inc;

  // An aborting cycle never accepts, so no new flags enter the delay line.
  assign w_feed_ok     = (r_state == S_FEED) && !abort;
  assign w_accept      = w_feed_ok && in_valid;
  assign w_vec_cnt_inc = r_vec_cnt + CNT_WIDTH'(1);
  // Only the final tap may still be set: that is the last vector's column COLS-1.
  assign w_drain_empty = ~|r_dly[DL-2:0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    w_load       = 1'b0;
    done         = 1'b0;
    w_start_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_take = 1'b1;
          w_state_next = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        w_load = 1'b1;
        if (r_row == LAST_ROW) begin
          w_state_next = (r_num_vec == '0) ? S_DRAIN : S_FEED;
        end
      end
      S_FEED: begin
        if (w_accept && (w_vec_cnt_inc == r_num_vec)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_empty) begin
          done         = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (abort) begin
      w_state_next = S_IDLE;
      done         = 1'b0;
      w_start_take = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_row <= '0;
    end else if ((r_state == S_LOAD_W) && !abort && (r_row != LAST_ROW)) begin
      r_row <= r_row + RSW'(1);
    end else begin
      r_row <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_num_vec <= '0;
      r_vec_cnt <= '0;
    end else if (abort) begin
      r_vec_cnt <= '0;
    end else if (w_start_take) begin
      r_num_vec <= num_vec;
      r_vec_cnt <= '0;
    end else if (w_accept) begin
      r_vec_cnt <= w_vec_cnt_inc;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dly <= '0;
    end else if (abort) begin
      r_dly <= '0;
    end else begin
      r_dly <= {r_dly[DL-2:0], w_accept};
    end
  end

  assign in_ready     = w_feed_ok;
  assign w_row_sel    = r_row;
  assign vec_cnt      = r_vec_cnt;
  assign x_feed_en[0] = w_accept;

  // Tap k of the delay line is high k+1 cycles after the accept.
  generate
    for (genvar gi = 1; gi < ROWS; gi++) begin : g_xskew
      assign x_feed_en[gi] = r_dly[gi-1];
    end
    for (genvar gi = 0; gi < COLS; gi++) begin : g_yvalid
      assign y_valid[gi] = r_dly[ROWS+gi];
    end
  endgenerate

endmodule
